// File: rtl/mcpu_pkg.sv
// mcpu_pkg: FSM states, RV32I opcode/funct constants, ALU operations and immediate decoding.
package mcpu_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_PASS
  } alu_op_t;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SR  = 3'd5;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_W   = 3'd2;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE = 3'd5;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  function automatic logic [31:0] imm_of(input logic [31:0] ir);
    return ir[6:0] == OP_STORE  ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
           ir[6:0] == OP_BRANCH ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
           ir[6:0] == OP_LUI    ? {ir[31:12], 12'b0} :
           ir[6:0] == OP_JAL    ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                                  {{20{ir[31]}}, ir[31:20]};
  endfunction
endpackage

// File: rtl/mcpu_regfile.sv
// mcpu_regfile: register file with two async read ports and one sync write port; x0 reads zero.
module mcpu_regfile #(
  parameter int NREGS = 32,
  parameter int DATAWIDTH = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        ra1,
  input  logic [AW-1:0]        ra2,
  output logic [DATAWIDTH-1:0] rd1,
  output logic [DATAWIDTH-1:0] rd2,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [DATAWIDTH-1:0] wd
);
  logic [DATAWIDTH-1:0] regs [NREGS];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (we && wa != '0) regs[wa] <= wd;
  assign rd1 = ra1 == '0 ? '0 : regs[ra1];
  assign rd2 = ra2 == '0 ? '0 : regs[ra2];
endmodule

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: RV32I-subset multi-cycle core sharing one memory port for fetch and data.
// Define MCPU_MULDIV_EN to add MUL; without it MUL decodes as illegal and halts.
module multi_cycle_cpu
  import mcpu_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NREGS = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic [DATAWIDTH-1:0] pc_out,
  output logic                 retire,
  output logic                 halted
);
  localparam int AW = $clog2(NREGS);
  localparam int SHW = $clog2(DATAWIDTH);
`ifdef MCPU_MULDIV_EN
  localparam bit HAS_MUL = 1'b1;
`else
  localparam bit HAS_MUL = 1'b0;
`endif
  state_t state;
  alu_op_t alu_op;
  logic go, is_r, is_ld, is_st, jump, legal, taken;
  logic [31:0] ir;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [DATAWIDTH-1:0] pc, pc4, a, b, imm, y, tgt, alu_r, alu_res, mdr, addr, rd1, rd2, wb_data;

  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign is_r = op == OP_R;
  assign is_ld = op == OP_LOAD;
  assign is_st = op == OP_STORE;
  assign jump = op == OP_JAL || op == OP_JALR;
  assign imm = DATAWIDTH'($signed(imm_of(ir)));
  assign y = is_r ? b : imm;
  assign pc4 = pc + DATAWIDTH'(4);
  assign tgt = op == OP_JAL ? pc + imm : (a + imm) & ~DATAWIDTH'(1);
  assign legal = (is_r && ((f7 == F7_BASE && f3 != 3'd3) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))
                           || (HAS_MUL && f7 == F7_MULDIV && f3 == F3_ADD)))
              || (op == OP_I && (f3 == F3_ADD || f3 == F3_SLT || f3 == F3_XOR || f3 == F3_OR || f3 == F3_AND))
              || op == OP_LUI || op == OP_JAL || (op == OP_JALR && f3 == 3'd0)
              || ((is_ld || is_st) && f3 == F3_W)
              || (op == OP_BRANCH && (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT || f3 == F3_BGE));
  assign alu_op = is_r && f7 == F7_MULDIV ? ALU_MUL :
                  op == OP_LUI ? ALU_PASS :
                  !(is_r || op == OP_I) ? ALU_ADD :
                  f3 == F3_ADD ? (is_r && f7 == F7_ALT ? ALU_SUB : ALU_ADD) :
                  f3 == F3_SLL ? ALU_SLL :
                  f3 == F3_SLT ? ALU_SLT :
                  f3 == F3_XOR ? ALU_XOR :
                  f3 == F3_SR ? (f7 == F7_ALT ? ALU_SRA : ALU_SRL) :
                  f3 == F3_OR ? ALU_OR : ALU_AND;
  assign taken = f3 == F3_BEQ ? a == b :
                 f3 == F3_BNE ? a != b :
                 f3 == F3_BLT ? $signed(a) < $signed(b) : $signed(a) >= $signed(b);

  always_comb begin
    alu_res = a + y;
    case (alu_op)
      ALU_SUB:  alu_res = a - y;
      ALU_AND:  alu_res = a & y;
      ALU_OR:   alu_res = a | y;
      ALU_XOR:  alu_res = a ^ y;
      ALU_SLT:  alu_res = DATAWIDTH'($signed(a) < $signed(y));
      ALU_SLL:  alu_res = a << y[SHW-1:0];
      ALU_SRL:  alu_res = a >> y[SHW-1:0];
      ALU_SRA:  alu_res = $signed(a) >>> y[SHW-1:0];
`ifdef MCPU_MULDIV_EN
      ALU_MUL:  alu_res = a * y;
`endif
      ALU_PASS: alu_res = y;
      default:  ;
    endcase
  end

  // go holds off the first fetch until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_r <= '0;
      mdr <= '0;
      go <= 1'b0;
    end else begin
      go <= 1'b1;
      case (state)
        S_FETCH: if (go && mem_ready) begin
          ir <= mem_rdata[31:0];
          state <= S_DECODE;
        end
        S_DECODE: begin
          a <= rd1;
          b <= rd2;
          state <= legal ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          alu_r <= jump ? tgt : alu_res;
          if (op == OP_BRANCH) pc <= taken ? pc + imm : pc4;
          state <= op == OP_BRANCH ? S_FETCH : (is_ld || is_st) ? S_MEM : S_WB;
        end
        S_MEM: if (mem_ready) begin
          mdr <= DATAWIDTH'($signed(mem_rdata[31:0]));
          if (is_st) pc <= pc4;
          state <= is_st ? S_FETCH : S_WB;
        end
        S_WB: begin
          pc <= jump ? alu_r : pc4;
          state <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

  assign wb_data = jump ? pc4 : is_ld ? mdr : alu_r;
  assign addr = state == S_MEM ? alu_r : pc;
  assign mem_addr = {addr[DATAWIDTH-1:2], 2'b00};
  assign mem_req = (state == S_FETCH && go) || state == S_MEM;
  assign mem_we = state == S_MEM && is_st;
  assign mem_wdata = b;
  assign pc_out = pc;
  assign halted = state == S_HALT;
  assign retire = state == S_WB || (state == S_EXEC && op == OP_BRANCH) || (state == S_MEM && is_st && mem_ready);

  mcpu_regfile #(.NREGS(NREGS), .DATAWIDTH(DATAWIDTH)) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(ir[15 +: AW]),
    .ra2(ir[20 +: AW]),
    .rd1(rd1),
    .rd2(rd2),
    .we(state == S_WB),
    .wa(ir[7 +: AW]),
    .wd(wb_data)
  );
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: directed programs against a word memory with configurable data-region wait states.
module tb_multi_cycle_cpu;
  logic clk = 1'b0, rst = 1'b0, mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [31:0] mem [64];
  logic [31:0] wa_q[$], wd_q[$];
  int wait_d = 0, cnt = 0, cy = 0, base = 0, n_vec = 0, n_err = 0;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  always #5 clk = ~clk;

  multi_cycle_cpu dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc_out(pc_out), .retire(retire), .halted(halted)
  );

  // code below 0x40 is zero-wait; the data region at 0x40+ inserts wait_d wait cycles
  assign mem_rdata = mem[mem_addr[7:2]];
  assign mem_ready = mem_req && cnt >= (mem_addr >= 32'h40 ? wait_d : 0);
  always @(posedge clk) begin
    cnt <= (mem_req && !mem_ready) ? cnt + 1 : 0;
    if (mem_req && mem_we && mem_ready) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic start(input int wd);
    rst = 1'b0;
    wait_d = wd;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cy = 0;
    base = wa_q.size();
  endtask

  task automatic step();
    @(negedge clk);
    cy++;
  endtask

  task automatic upto(input int n);
    while (cy < n) step();
  endtask

  task automatic run_halt(input string tag);
    int k = 0;
    while (!halted && k < 300) begin
      step();
      k++;
    end
    chk(tag, halted, 1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    chk({tag, "_addr"}, wa_q[base + idx], ea);
    chk({tag, "_data"}, wd_q[base + idx], ed);
  endtask

  initial begin
    // ADDI/ADDI/ADD retire cadence, then SW with two wait cycles, then EBREAK
    clr();
    mem[0] = enc_i(5, 0, 0, 1, 7'h13);
    mem[1] = enc_i(7, 0, 0, 2, 7'h13);
    mem[2] = enc_r(0, 2, 1, 0, 3);
    mem[3] = enc_s(32'h40, 3, 0);
    mem[4] = EBREAK;
    start(2);
    chk("rst_req", mem_req, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    for (int c = 1; c <= 12; c++) begin
      upto(c);
      chk($sformatf("alu_retire_c%0d", c), retire, (c % 4 == 0) ? 1 : 0);
      if (c == 1) begin
        chk("first_fetch_req", mem_req, 1);
        chk("first_fetch_addr", mem_addr, 0);
      end
    end
    for (int c = 16; c <= 17; c++) begin
      upto(c);
      chk("sw_wait_req", mem_req, 1);
      chk("sw_wait_we", mem_we, 1);
      chk("sw_wait_addr", mem_addr, 32'h40);
      chk("sw_wait_wdata", mem_wdata, 12);
      chk("sw_wait_retire", retire, 0);
    end
    upto(18);
    chk("sw_retire", retire, 1);
    upto(21);
    chk("ebreak_halted", halted, 1);
    chk("ebreak_req", mem_req, 0);
    upto(25);
    chk("halt_req_held", mem_req, 0);
    chk("halt_pc", pc_out, 32'h10);
    chk("sw_count", wa_q.size() - base, 1);
    chk_wr("sw", 0, 32'h40, 12);

    // JAL to 0x10, BEQ taken back to 0x08, store the JAL link
    clr();
    mem[0] = enc_i(5, 0, 0, 1, 7'h13);
    mem[1] = enc_j(12, 5);
    mem[2] = enc_s(32'h44, 5, 0);
    mem[3] = EBREAK;
    mem[4] = enc_b(-8, 1, 1, 0);
    start(0);
    upto(9);
    chk("jal_fetch_addr", mem_addr, 32'h10);
    upto(10);
    chk("beq_decode_retire", retire, 0);
    upto(11);
    chk("beq_retire", retire, 1);
    upto(12);
    chk("beq_target_addr", mem_addr, 32'h08);
    chk("beq_target_req", mem_req, 1);
    run_halt("beq_halt");
    chk("beq_pc", pc_out, 32'h0C);
    chk("jal_count", wa_q.size() - base, 1);
    chk_wr("jal_link", 0, 32'h44, 32'h08);

    // BNE not taken falls through to 0x14
    mem[4] = enc_b(-8, 1, 1, 1);
    mem[5] = EBREAK;
    start(0);
    upto(11);
    chk("bne_retire", retire, 1);
    upto(12);
    chk("bne_fall_addr", mem_addr, 32'h14);
    run_halt("bne_halt");
    chk("bne_pc", pc_out, 32'h14);
    chk("bne_count", wa_q.size() - base, 0);

    // x0 stays zero; opcode 0x7F halts
    clr();
    mem[0] = enc_i(9, 0, 0, 4, 7'h13);
    mem[1] = enc_i(1, 0, 0, 0, 7'h13);
    mem[2] = enc_r(0, 0, 0, 0, 4);
    mem[3] = enc_s(32'h48, 4, 0);
    mem[4] = 32'h0000_007F;
    start(0);
    upto(18);
    chk("ill_decode_halted", halted, 0);
    upto(19);
    chk("ill_halted", halted, 1);
    chk("ill_req", mem_req, 0);
    upto(23);
    chk("ill_req_held", mem_req, 0);
    chk("ill_retire", retire, 0);
    chk("ill_pc", pc_out, 32'h10);
    chk("x0_count", wa_q.size() - base, 1);
    chk_wr("x0", 0, 32'h48, 0);

    // reset during a waiting LW, then a clean LW/SW run
    clr();
    mem[0] = enc_i(32'h40, 0, 2, 6, 7'h03);
    mem[1] = enc_s(32'h44, 6, 0);
    mem[2] = EBREAK;
    mem[16] = 32'h8765_4321;
    start(5);
    upto(4);
    chk("lw_mem_req", mem_req, 1);
    chk("lw_mem_addr", mem_addr, 32'h40);
    chk("lw_mem_we", mem_we, 0);
    upto(5);
    #1 rst = 1'b0;
    #1 chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_pc", pc_out, 0);
    chk("rst_mid_retire", retire, 0);
    wait_d = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cy = 0;
    chk("rel_req", mem_req, 0);
    upto(1);
    chk("rel_fetch_req", mem_req, 1);
    chk("rel_fetch_addr", mem_addr, 0);
    upto(4);
    chk("lw_mem_retire", retire, 0);
    upto(5);
    chk("lw_retire", retire, 1);
    run_halt("lw_halt");
    chk("lw_count", wa_q.size() - base, 1);
    chk_wr("lw", 0, 32'h44, 32'h8765_4321);

    // SRA, SLT, LUI, SUB, XORI patterns
    clr();
    mem[0]  = enc_i(-16, 0, 0, 1, 7'h13);
    mem[1]  = enc_i(2, 0, 0, 2, 7'h13);
    mem[2]  = enc_r(32'h20, 2, 1, 5, 3);
    mem[3]  = enc_s(32'h40, 3, 0);
    mem[4]  = enc_r(0, 2, 1, 2, 4);
    mem[5]  = enc_s(32'h44, 4, 0);
    mem[6]  = enc_u(32'h12345, 5, 7'h37);
    mem[7]  = enc_s(32'h48, 5, 0);
    mem[8]  = enc_r(32'h20, 1, 2, 0, 6);
    mem[9]  = enc_i(15, 6, 4, 7, 7'h13);
    mem[10] = enc_s(32'h4C, 7, 0);
    mem[11] = EBREAK;
    start(1);
    run_halt("alu_halt");
    chk("alu_count", wa_q.size() - base, 4);
    chk_wr("sra", 0, 32'h40, 32'hFFFF_FFFC);
    chk_wr("slt", 1, 32'h44, 1);
    chk_wr("lui", 2, 32'h48, 32'h1234_5000);
    chk_wr("sub_xori", 3, 32'h4C, 32'h1D);

    // JALR target clears bit 0 and links PC+4
    clr();
    mem[0] = enc_i(32'h11, 0, 0, 1, 7'h13);
    mem[1] = enc_i(0, 1, 0, 2, 7'h67);
    mem[4] = enc_s(32'h40, 2, 0);
    mem[5] = EBREAK;
    start(0);
    run_halt("jalr_halt");
    chk("jalr_pc", pc_out, 32'h14);
    chk("jalr_count", wa_q.size() - base, 1);
    chk_wr("jalr_link", 0, 32'h40, 32'h08);

    // MUL 0xFFFFFFFF * 2
    clr();
    mem[0] = enc_i(-1, 0, 0, 1, 7'h13);
    mem[1] = enc_i(2, 0, 0, 2, 7'h13);
    mem[2] = enc_r(1, 2, 1, 0, 7);
    mem[3] = enc_s(32'h40, 7, 0);
    mem[4] = EBREAK;
    start(0);
`ifdef MCPU_MULDIV_EN
    upto(12);
    chk("mul_retire", retire, 1);
    run_halt("mul_halt");
    chk("mul_pc", pc_out, 32'h10);
    chk("mul_count", wa_q.size() - base, 1);
    chk_wr("mul", 0, 32'h40, 32'hFFFF_FFFE);
`else
    upto(11);
    chk("mul_ill_halted", halted, 1);
    chk("mul_ill_req", mem_req, 0);
    chk("mul_ill_pc", pc_out, 32'h08);
    upto(14);
    chk("mul_ill_count", wa_q.size() - base, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
